// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: captures CPU OUT-port bytes into a FIFO and sends them as 8N1 UART frames, LSB first.
// A frame that ends with bytes still queued rolls straight into the next start bit.
module out_port_uart_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              out_data,
  input  logic                    out_valid,
  output logic                    tx,
  output logic                    busy,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q, overflow_q;
  logic          baud_end, pop, push;
  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level      = wr_ptr_q - rd_ptr_q;
  assign baud_end   = baud_q == CW'(CLKS_PER_BIT - 1);
  // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
  assign pop        = !fifo_empty && (state_q == IDLE || (state_q == STOP && baud_end));
  assign push       = out_valid && (!fifo_full || pop);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= out_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (out_valid && !push) overflow_q <= 1'b1;
      baud_q <= (state_q == IDLE || baud_end) ? '0 : baud_q + CW'(1);
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          shift_q <= mem_q[rd_ptr_q[AW-1:0]];
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        START: if (baud_end) begin
          state_q <= DATA;
          bit_q   <= '0;
          tx_q    <= shift_q[0];
        end
        DATA: if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
            bit_q   <= bit_q + 3'd1;
          end
        end
        STOP: if (baud_end) begin
          if (pop) begin
            state_q <= START;
            shift_q <= mem_q[rd_ptr_q[AW-1:0]];
            tx_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx: queue-based line model checked every cycle, plus an independent UART receiver
// and literal expectations for the directed scenarios.
module tb_out_port_uart_tx;
  localparam int CPB = 4, DEPTH = 4;
  logic clk = 0, reset = 0, out_valid = 0;
  logic [7:0] out_data = 0;
  logic tx, busy, fifo_full, fifo_empty, overflow;
  logic [2:0] level;
  int errors = 0, checks = 0;
  bit armed = 0, m_rst = 0;
  logic [7:0] m_fifo[$];
  logic m_line[$];
  logic m_tx = 1, m_busy = 0, m_ovf = 0, m_full = 0, m_popped = 0;
  logic [9:0] fr;
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = 0;
  bit rx_busy = 0;
  int rc = 0;

  out_port_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .out_data(out_data), .out_valid(out_valid), .tx(tx), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each accepted pop appends a whole frame's worth of per-cycle line values.
  always @(posedge clk) begin
    m_rst = reset;
    if (reset) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 0;
    end else begin
      m_full = m_fifo.size() == DEPTH;
      m_popped = 0;
      if (m_line.size() == 0 && m_fifo.size() > 0) begin
        fr = {1'b1, m_fifo.pop_front(), 1'b0};
        for (int b = 0; b < 10; b++) repeat (CPB) m_line.push_back(fr[b]);
        m_popped = 1;
      end
      if (out_valid) begin
        if (!m_full || m_popped) m_fifo.push_back(out_data);
        else m_ovf = 1;
      end
    end
    m_busy = m_line.size() > 0;
    m_tx = m_busy ? m_line.pop_front() : 1'b1;
  end

  always @(negedge clk) if (armed) begin
    chk("tx", tx, m_tx);
    chk("busy", busy, m_busy);
    chk("level", level, m_fifo.size());
    chk("fifo_full", fifo_full, m_fifo.size() == DEPTH);
    chk("fifo_empty", fifo_empty, m_fifo.size() == 0);
    chk("overflow", overflow, m_ovf);
  end

  always @(negedge clk) begin
    if (m_rst) rx_busy = 0;
    else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1;
        rc = 0;
      end
    end else begin
      rc++;
      if (rc % CPB == CPB / 2 && rc / CPB >= 1 && rc / CPB <= 8) rx_sh[rc / CPB - 1] = tx;
      if (rc == 9 * CPB + CPB / 2) begin
        chk("stop_bit", tx, 1);
        rx_q.push_back(rx_sh);
        rx_busy = 0;
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    out_valid = v;
    out_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
  endtask

  task automatic expect_rx(input logic [7:0] first, input int n);
    chk("rx_count", rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) chk("rx_byte", rx_q[i], first + 8'(i));
  endtask

  logic [9:0] a5_frame = 10'b1_10100101_0;

  initial begin
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    armed = 1;
    reset_pulse();
    // 1: single byte, exact waveform and busy fall at N+41
    rx_q.delete();
    step(1, 8'hA5);
    step(0, 8'h00);
    chk("t1_level_n", level, 1);
    for (int k = 1; k <= 41; k++) begin
      step(0, 8'h00);
      if (k <= 40) begin
        chk("t1_tx", tx, a5_frame[(k - 1) / CPB]);
        chk("t1_busy", busy, 1);
      end else begin
        chk("t1_busy_fall", busy, 0);
        chk("t1_level", level, 0);
      end
    end
    expect_rx(8'hA5, 1);
    // 2: back-to-back frames keep busy high for 80 cycles
    rx_q.delete();
    step(1, 8'h01);
    step(1, 8'h02);
    for (int k = 1; k <= 81; k++) begin
      step(0, 8'h00);
      chk("t2_busy", busy, k <= 80);
    end
    expect_rx(8'h01, 2);
    // 3: six bytes from idle, last one dropped
    rx_q.delete();
    step(1, 8'h10);
    for (int i = 1; i <= 5; i++) step(1, 8'h10 + 8'(i));
    chk("t3_full", fifo_full, 1);
    chk("t3_level", level, 4);
    chk("t3_ovf_pre", overflow, 0);
    step(0, 8'h00);
    chk("t3_ovf", overflow, 1);
    idle(230);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_drained", level, 0);
    expect_rx(8'h10, 5);
    // 4: push while full on the STOP->START pop edge
    reset_pulse();
    rx_q.delete();
    for (int i = 0; i <= 4; i++) step(1, 8'h20 + 8'(i));
    idle(36);
    chk("t4_full_pre", fifo_full, 1);
    step(1, 8'h25);
    step(0, 8'h00);
    chk("t4_level", level, 4);
    chk("t4_ovf", overflow, 0);
    chk("t4_full", fifo_full, 1);
    idle(210);
    expect_rx(8'h20, 6);
    // 5: reset during DATA bit 3, then a clean frame
    step(1, 8'h5A);
    idle(17);
    chk("t5_busy_pre", busy, 1);
    reset_pulse();
    rx_q.delete();
    step(1, 8'h3C);
    idle(50);
    expect_rx(8'h3C, 1);
    // 6: bus noise without a strobe is ignored
    for (int i = 0; i < 100; i++) begin
      step(0, 8'($urandom));
      chk("t6_tx", tx, 1);
      chk("t6_level", level, 0);
      chk("t6_busy", busy, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
